hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/div_seq.sv | 64 ++++++
 rtl/hazard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared hazard-unit types: forwarding-select encoding and divider sequencer states.
// Also used by the E-stage operand muxes, so keep the FWD_* encodings stable.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RD = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    localparam int unsigned CNT_W = 6;

    // Memory stage wins over Writeback because it holds the younger value.
    function automatic fwd_sel_e fwd_select(input logic       regwrite_m,
                                            input logic [4:0] rd_m,
                                            input logic       regwrite_w,
                                            input logic [4:0] rd_w,
                                            input logic [4:0] rs);
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_M;
        end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_W;
        end
        return FWD_RD;
    endfunction

endpackage

// File: rtl/div_seq.sv
// Iterative-divider sequencer: IDLE -> BUSY (DIV_CYCLES cycles) -> DONE -> IDLE.
// busy_o covers the start cycle plus BUSY; done_o is a one-cycle result-valid pulse.
module div_seq
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o,
    output logic done_o
);

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(DIV_CYCLES - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    state_d = DIV_BUSY;
                    cnt_d   = CntLoad;
                    busy_o  = 1'b1;
                end
            end
            DIV_BUSY: begin
                busy_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DIV_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_DONE: begin
                // start_i is deliberately ignored here; a new divide enters from IDLE.
                done_o  = 1'b1;
                state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
        if (rst) begin
            busy_o = 1'b0;
            done_o = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush, divider stall.
// Define HAZARD_PERF_CNT_EN to add stallcnt/flushcnt performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1D,
    input  logic [4:0] rs2D,
    input  logic [4:0] rs1E,
    input  logic [4:0] rs2E,
    input  logic [4:0] rdE,
    input  logic [4:0] rdM,
    input  logic [4:0] rdW,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       loadE,
    input  logic       pcsrcE,
    input  logic       divstartE,
    output logic [1:0] forwardaE,
    output logic [1:0] forwardbE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       divbusy,
    output logic       divdoneE
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stallcnt,
    output logic [31:0] flushcnt
`endif
);

    fwd_sel_e fwd_a, fwd_b;
    logic     lwstall;
    logic     div_busy;
    logic     div_done;

    div_seq #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div_seq (
        .clk    (clk),
        .rst    (rst),
        .start_i(divstartE),
        .busy_o (div_busy),
        .done_o (div_done)
    );

    always_comb begin
        fwd_a = fwd_select(regwriteM, rdM, regwriteW, rdW, rs1E);
        fwd_b = fwd_select(regwriteM, rdM, regwriteW, rdW, rs2E);
        if (rst) begin
            fwd_a = FWD_RD;
            fwd_b = FWD_RD;
        end
    end

    assign forwardaE = fwd_a;
    assign forwardbE = fwd_b;
    assign lwstall   = loadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
    assign divbusy   = div_busy;
    assign divdoneE  = div_done;

    // Divider activity freezes the front end and masks branch/load hazards entirely.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (!rst) begin
            if (div_busy) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
            end else if (pcsrcE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (lwstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallcnt_q, stallcnt_d;
    logic [31:0] flushcnt_q, flushcnt_d;

    always_comb begin
        stallcnt_d = stallcnt_q + {31'b0, stallF};
        flushcnt_d = flushcnt_q + {31'b0, flushE};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stallcnt_q <= '0;
            flushcnt_q <= '0;
        end else begin
            stallcnt_q <= stallcnt_d;
            flushcnt_q <= flushcnt_d;
        end
    end

    assign stallcnt = stallcnt_q;
    assign flushcnt = flushcnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (DIV_CYCLES = 4); expected output vectors are
// queued as stimulus is applied and popped when sampled on the falling edge.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       regwriteM, regwriteW, loadE, pcsrcE, divstartE;
    logic [1:0] forwardaE, forwardbE;
    logic       stallF, stallD, stallE, flushD, flushE, divbusy, divdoneE;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallcnt, flushcnt;
`endif

    // {fa[1:0], fb[1:0], stallF, stallD, stallE, flushD, flushE, divbusy, divdoneE}
    logic [10:0] obs;
    logic [10:0] exp_q[$];
    int          checks = 0;
    int          passed = 0;

    assign obs = {forwardaE, forwardbE, stallF, stallD, stallE, flushD, flushE, divbusy,
                  divdoneE};

    hazard_ctrl #(
        .DIV_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rs1D     (rs1D),
        .rs2D     (rs2D),
        .rs1E     (rs1E),
        .rs2E     (rs2E),
        .rdE      (rdE),
        .rdM      (rdM),
        .rdW      (rdW),
        .regwriteM(regwriteM),
        .regwriteW(regwriteW),
        .loadE    (loadE),
        .pcsrcE   (pcsrcE),
        .divstartE(divstartE),
        .forwardaE(forwardaE),
        .forwardbE(forwardbE),
        .stallF   (stallF),
        .stallD   (stallD),
        .stallE   (stallE),
        .flushD   (flushD),
        .flushE   (flushE),
        .divbusy  (divbusy),
        .divdoneE (divdoneE)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stallcnt (stallcnt),
        .flushcnt (flushcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_in();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0;
        rdE = 0; rdM = 0; rdW = 0;
        regwriteM = 0; regwriteW = 0;
        loadE = 0; pcsrcE = 0; divstartE = 0;
    endtask

    task automatic test_reset();
        logic [10:0] exp_v;
        for (int i = 0; i < 3; i++) begin
            clear_in();
            rst = (i < 2);
            if (i < 2) begin
                rdM = 5; rs1E = 5; regwriteM = 1;
                loadE = 1; rdE = 7; rs2D = 7; pcsrcE = 1; divstartE = 1;
            end
            exp_q.push_back(11'b0);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) $display("FAIL reset[%0d] got=%b exp=%b", i, obs, exp_v);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forwarding();
        logic [10:0] exp_v;
        for (int i = 0; i < 5; i++) begin
            clear_in();
            case (i)
                0: begin
                    rdM = 5; rdW = 5; rs1E = 5; regwriteM = 1; regwriteW = 1;
                    exp_q.push_back({2'b10, 2'b00, 7'b0});
                end
                1: begin
                    rdM = 5; rdW = 5; rs1E = 5; regwriteM = 0; regwriteW = 1;
                    exp_q.push_back({2'b01, 2'b00, 7'b0});
                end
                2: begin
                    regwriteM = 1; regwriteW = 1;
                    exp_q.push_back({2'b00, 2'b00, 7'b0});
                end
                3: begin
                    rdM = 3; rs1E = 3; regwriteM = 1; rdW = 9; rs2E = 9; regwriteW = 1;
                    exp_q.push_back({2'b10, 2'b01, 7'b0});
                end
                default: begin
                    rs1E = 12; rs2E = 12; rdM = 12; rdW = 12; regwriteM = 1; regwriteW = 1;
                    exp_q.push_back({2'b10, 2'b10, 7'b0});
                end
            endcase
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) $display("FAIL fwd[%0d] got=%b exp=%b", i, obs, exp_v);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        logic [10:0] exp_v;
        for (int i = 0; i < 7; i++) begin
            clear_in();
            case (i)
                0: begin
                    loadE = 1; rdE = 7; rs2D = 7;
                    exp_q.push_back({4'b0, 7'b1100100});
                end
                1: begin
                    rdE = 7; rs2D = 7;
                    exp_q.push_back(11'b0);
                end
                2: begin
                    loadE = 1; rdE = 7; rs2D = 7; pcsrcE = 1;
                    exp_q.push_back({4'b0, 7'b0001100});
                end
                3: begin
                    loadE = 1;
                    exp_q.push_back(11'b0);
                end
                4: begin
                    loadE = 1; rdE = 4; rs1D = 4;
                    exp_q.push_back({4'b0, 7'b1100100});
                end
                5: begin
                    rdE = 4; rs1D = 4;
                    exp_q.push_back(11'b0);
                end
                default: begin
                    pcsrcE = 1;
                    exp_q.push_back({4'b0, 7'b0001100});
                end
            endcase
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) $display("FAIL loaduse[%0d] got=%b exp=%b", i, obs, exp_v);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    // Start cycle + 4 BUSY cycles stall; hazards in those cycles are masked.
    task automatic test_divider();
        logic [10:0] exp_v;
        logic        b, d;
        for (int i = 0; i < 7; i++) begin
            clear_in();
            divstartE = (i == 0);
            if (i <= 1) begin
                loadE = 1; rdE = 7; rs2D = 7; pcsrcE = 1;
                rdM = 5; rs1E = 5; regwriteM = 1;
            end
            b = (i <= 4);
            d = (i == 5);
            exp_q.push_back({(i <= 1) ? 2'b10 : 2'b00, 2'b00, b, b, b, 2'b00, b, d});
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) $display("FAIL div[%0d] got=%b exp=%b", i, obs, exp_v);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_v;
        logic        b, d;
        for (int i = 0; i < 13; i++) begin
            clear_in();
            divstartE = (i < 12);
            b = (i <= 4) || ((i >= 6) && (i <= 10));
            d = (i == 5) || (i == 11);
            exp_q.push_back({4'b0, b, b, b, 2'b00, b, d});
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) $display("FAIL b2b[%0d] got=%b exp=%b", i, obs, exp_v);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    // Reset lands while cnt == 2; no done pulse may follow.
    task automatic test_reset_mid_busy();
        logic [10:0] exp_v;
        logic        b;
        for (int i = 0; i < 6; i++) begin
            clear_in();
            divstartE = (i == 0);
            rst = (i == 2);
            b = (i <= 1);
            exp_q.push_back({4'b0, b, b, b, 2'b00, b, 1'b0});
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) $display("FAIL rstbusy[%0d] got=%b exp=%b", i, obs, exp_v);
            else passed++;
            @(posedge clk); #1;
        end
        rst = 0;
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_counters();
        logic [10:0] exp_v;
        for (int i = 0; i < 11; i++) begin
            clear_in();
            rst = (i == 0);
            case (i)
                1, 5: begin
                    loadE = 1; rdE = 7; rs2D = 7;
                    exp_q.push_back({4'b0, 7'b1100100});
                end
                3: begin
                    loadE = 1; rdE = 9; rs1D = 9;
                    exp_q.push_back({4'b0, 7'b1100100});
                end
                7, 9: begin
                    pcsrcE = 1;
                    exp_q.push_back({4'b0, 7'b0001100});
                end
                default: exp_q.push_back(11'b0);
            endcase
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) $display("FAIL perf[%0d] got=%b exp=%b", i, obs, exp_v);
            else passed++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (stallcnt !== 32'd3) $display("FAIL stallcnt got=%0d exp=3", stallcnt);
        else passed++;
        checks++;
        if (flushcnt !== 32'd5) $display("FAIL flushcnt got=%0d exp=5", flushcnt);
        else passed++;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_in();
        test_reset();
        test_forwarding();
        test_load_use();
        test_divider();
        test_back_to_back();
        test_reset_mid_busy();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
